// File: rtl/flow_ctrl_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl_monitor_pkg
// Description : Shared constants for the flow-control monitor and the FSM
//               control block: FIFO bit indices, FIFO depths, counter and
//               threshold widths, and umbrales_I field layout.
// Revision    : 1.0 - initial release
// ============================================================================
package flow_ctrl_monitor_pkg;

    // Bit position of each FIFO on every 5-bit status/strobe vector
    localparam int c_fifo_num   = 5;
    localparam int c_idx_mf     = 4;
    localparam int c_idx_vc0    = 3;
    localparam int c_idx_vc1    = 2;
    localparam int c_idx_d0     = 1;
    localparam int c_idx_d1     = 0;

    // Depths: small FIFOs (MF/D0/D1) and large FIFOs (VC0/VC1)
    localparam int c_depth_s    = 4;
    localparam int c_depth_l    = 16;

    // Occupancy counters span 0..DEPTH inclusive
    localparam int c_cnt_w_s    = 3;
    localparam int c_cnt_w_l    = 5;

    // Threshold field widths and umbrales_I layout
    localparam int c_thr_w_s    = 2;
    localparam int c_thr_w_l    = 4;
    localparam int c_umbrales_w = 14;
    localparam int c_thr_lsb_mf  = 12;
    localparam int c_thr_lsb_vc0 = 8;
    localparam int c_thr_lsb_vc1 = 4;
    localparam int c_thr_lsb_d0  = 2;
    localparam int c_thr_lsb_d1  = 0;

    // VC0/VC1 are the deep FIFOs; the rest are shallow
    function automatic bit fifo_is_large(input int idx);
        return (idx == c_idx_vc0) || (idx == c_idx_vc1);
    endfunction

    function automatic int fifo_thr_w(input int idx);
        return fifo_is_large(idx) ? c_thr_w_l : c_thr_w_s;
    endfunction

    function automatic int fifo_thr_lsb(input int idx);
        int lsb;
        case (idx)
            c_idx_mf:  lsb = c_thr_lsb_mf;
            c_idx_vc0: lsb = c_thr_lsb_vc0;
            c_idx_vc1: lsb = c_thr_lsb_vc1;
            c_idx_d0:  lsb = c_thr_lsb_d0;
            default:   lsb = c_thr_lsb_d1;
        endcase
        return lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_occupancy.sv
`default_nettype none
// ============================================================================
// Module      : fifo_occupancy
// Description : Occupancy tracker for one FIFO: saturating 0..DEPTH counter,
//               threshold register, sticky overflow/underflow flag and
//               almost-full / almost-empty / empty decode.
// Ports       : clk            - clock, rising edge
//               reset          - synchronous active-low reset
//               i_init         - load i_thr into the threshold register
//               i_thr          - threshold value
//               i_push/i_pop   - write / read strobes
//               o_almost_full  - count >= DEPTH - threshold
//               o_almost_empty - count <= threshold
//               o_empty        - count == 0
//               o_error        - sticky overflow/underflow
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_occupancy #(
    parameter int DEPTH = 4,
    parameter int THR_W = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_init,
    input  logic [THR_W-1:0] i_thr,
    input  logic             i_push,
    input  logic             i_pop,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_empty,
    output logic             o_error
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_zero  = '0;
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [THR_W-1:0] r_thr;
    logic             r_error;
    logic [CNT_W-1:0] w_thr_ext;
    logic [CNT_W-1:0] w_full_lvl;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_thr   <= '0;
            r_error <= 1'b0;
        end else begin
            if (i_init) begin
                r_thr <= i_thr;
            end
            // Simultaneous push+pop is a pass-through and never an error,
            // even when empty or full.
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == c_depth) r_error <= 1'b1;
                    else                    r_count <= r_count + c_one;
                end
                2'b01: begin
                    if (r_count == c_zero) r_error <= 1'b1;
                    else                   r_count <= r_count - c_one;
                end
                default: ;
            endcase
        end
    end

    // Threshold never exceeds DEPTH-1, so this difference cannot wrap.
    assign w_thr_ext  = CNT_W'(r_thr);
    assign w_full_lvl = c_depth - w_thr_ext;

    assign o_almost_full  = (r_count >= w_full_lvl);
    assign o_almost_empty = (r_count <= w_thr_ext);
    assign o_empty        = (r_count == c_zero);
    assign o_error        = r_error;

endmodule
`default_nettype wire

// File: rtl/flow_ctrl_monitor.sv
`default_nettype none
// ============================================================================
// Module      : flow_ctrl_monitor
// Description : Occupancy/status monitor for five independent FIFOs
//               (MF, VC0, VC1, D0, D1). Bit order on every 5-bit vector is
//               MF=4, VC0=3, VC1=2, D0=1, D1=0.
// Ports       : clk          - clock, rising edge
//               reset        - synchronous active-low reset
//               init         - latch all thresholds from umbrales_I
//               umbrales_I   - {MF[13:12],VC0[11:8],VC1[7:4],D0[3:2],D1[1:0]}
//               push/pop     - per-FIFO write/read strobes
//               almost_full  - per-FIFO upper-threshold status
//               almost_empty - per-FIFO lower-threshold status
//               FIFO_empty   - per-FIFO zero occupancy
//               FIFO_error   - per-FIFO sticky overflow/underflow
// Revision    : 1.0 - initial release
// ============================================================================
module flow_ctrl_monitor
    import flow_ctrl_monitor_pkg::*;
#(
    parameter int DEPTH_S = c_depth_s,
    parameter int DEPTH_L = c_depth_l
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [c_umbrales_w-1:0] umbrales_I,
    input  logic [c_fifo_num-1:0]   push,
    input  logic [c_fifo_num-1:0]   pop,
    output logic [c_fifo_num-1:0]   almost_full,
    output logic [c_fifo_num-1:0]   almost_empty,
    output logic [c_fifo_num-1:0]   FIFO_empty,
    output logic [c_fifo_num-1:0]   FIFO_error
);

    for (genvar gi = 0; gi < c_fifo_num; gi++) begin : g_fifo
        localparam int c_depth = fifo_is_large(gi) ? DEPTH_L : DEPTH_S;
        localparam int c_thr_w = fifo_thr_w(gi);
        localparam int c_lsb   = fifo_thr_lsb(gi);
        localparam int c_cnt_w = $clog2(c_depth + 1);

        fifo_occupancy #(
            .DEPTH (c_depth),
            .THR_W (c_thr_w),
            .CNT_W (c_cnt_w)
        ) u_occ (
            .clk            (clk),
            .reset          (reset),
            .i_init         (init),
            .i_thr          (umbrales_I[c_lsb +: c_thr_w]),
            .i_push         (push[gi]),
            .i_pop          (pop[gi]),
            .o_almost_full  (almost_full[gi]),
            .o_almost_empty (almost_empty[gi]),
            .o_empty        (FIFO_empty[gi]),
            .o_error        (FIFO_error[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_flow_ctrl_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_flow_ctrl_monitor
// Description : Directed self-checking bench for flow_ctrl_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_ctrl_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [13:0] umbrales_I;
    logic [4:0]  push;
    logic [4:0]  pop;
    logic [4:0]  almost_full;
    logic [4:0]  almost_empty;
    logic [4:0]  FIFO_empty;
    logic [4:0]  FIFO_error;

    int checks = 0;
    int errors = 0;

    localparam logic [13:0] c_u1   = {2'd1, 4'd4, 4'd12, 2'd1, 2'd3};
    localparam logic [13:0] c_u2   = {2'd1, 4'd4, 4'd12, 2'd2, 2'd3};
    localparam logic [13:0] c_umax = {2'd3, 4'd15, 4'd15, 2'd3, 2'd3};

    flow_ctrl_monitor #(.DEPTH_S(4), .DEPTH_L(16)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbrales_I   (umbrales_I),
        .push         (push),
        .pop          (pop),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .FIFO_empty   (FIFO_empty),
        .FIFO_error   (FIFO_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the edge.
    task automatic cyc(input logic [4:0] pu, input logic [4:0] po, input logic in,
                       input logic [13:0] u, input logic rn);
        push = pu; pop = po; init = in; umbrales_I = u; reset = rn;
        @(posedge clk);
        #1;
        push = '0; pop = '0; init = 1'b0; reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        push = '0; pop = '0; init = 1'b0; umbrales_I = '0; reset = 1'b0;

        // Reset values
        cyc(5'b0, 5'b0, 1'b0, 14'd0, 1'b0);
        cyc(5'b0, 5'b0, 1'b0, 14'd0, 1'b0);
        check("rst_empty", FIFO_empty,   5'b11111);
        check("rst_ae",    almost_empty, 5'b11111);
        check("rst_af",    almost_full,  5'b00000);
        check("rst_err",   FIFO_error,   5'b00000);

        // Threshold load
        cyc(5'b0, 5'b0, 1'b1, c_u1, 1'b1);
        check("init_ae", almost_empty, 5'b11111);
        check("init_af", almost_full,  5'b00000);

        // VC0 threshold decode: ae until 4, af from 12
        for (int k = 1; k <= 12; k++) begin
            cyc(5'b01000, 5'b0, 1'b0, 14'd0, 1'b1);
            if (k == 4)  check("vc0_ae_4",  almost_empty, 5'b11111);
            if (k == 5)  check("vc0_ae_5",  almost_empty, 5'b10111);
            if (k == 5)  check("vc0_emp_5", FIFO_empty,   5'b10111);
            if (k == 11) check("vc0_af_11", almost_full,  5'b00000);
            if (k == 12) check("vc0_af_12", almost_full,  5'b01000);
        end

        // D1 underflow, count must remain 0
        cyc(5'b0, 5'b00001, 1'b0, 14'd0, 1'b1);
        check("d1_uf_err", FIFO_error, 5'b00001);
        check("d1_uf_emp", FIFO_empty, 5'b10111);
        cyc(5'b00001, 5'b0, 1'b0, 14'd0, 1'b1);
        check("d1_push_emp", FIFO_empty,  5'b10110);
        check("d1_push_af",  almost_full, 5'b01001);
        cyc(5'b0, 5'b00001, 1'b0, 14'd0, 1'b1);
        check("d1_pop_emp", FIFO_empty, 5'b10111);
        check("d1_sticky",  FIFO_error, 5'b00001);

        // Reset overrides push
        cyc(5'b11111, 5'b0, 1'b0, 14'd0, 1'b0);
        check("rst2_empty", FIFO_empty,   5'b11111);
        check("rst2_err",   FIFO_error,   5'b00000);
        check("rst2_ae",    almost_empty, 5'b11111);
        check("rst2_af",    almost_full,  5'b00000);

        // Simultaneous push+pop on full VC1 and empty D0
        cyc(5'b0, 5'b0, 1'b1, c_u1, 1'b1);
        for (int k = 0; k < 16; k++) cyc(5'b00100, 5'b0, 1'b0, 14'd0, 1'b1);
        check("vc1_full_af", almost_full, 5'b00100);
        cyc(5'b00110, 5'b00110, 1'b0, 14'd0, 1'b1);
        check("pp_err", FIFO_error,  5'b00000);
        check("pp_emp", FIFO_empty,  5'b11011);
        check("pp_af",  almost_full, 5'b00100);
        // Counts must still be 16 and 0: single strobes now fault
        cyc(5'b00100, 5'b00010, 1'b0, 14'd0, 1'b1);
        check("pp_cnt_err", FIFO_error, 5'b00110);
        check("pp_cnt_emp", FIFO_empty, 5'b11011);

        // MF overflow with VC0 at 9 (thresholds zero after reset)
        cyc(5'b0, 5'b0, 1'b0, 14'd0, 1'b0);
        for (int k = 0; k < 9; k++) cyc(5'b01000, 5'b0, 1'b0, 14'd0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            cyc(5'b10000, 5'b0, 1'b0, 14'd0, 1'b1);
            if (k == 4) check("mf_full_err", FIFO_error,  5'b00000);
            if (k == 4) check("mf_full_af",  almost_full, 5'b10000);
            if (k == 5) check("mf_ovf_err",  FIFO_error,  5'b10000);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(5'b0, 5'b10000, 1'b0, 14'd0, 1'b1);
            if (k == 3) check("mf_pop3_emp", FIFO_empty, 5'b00111);
            if (k == 4) check("mf_pop4_emp", FIFO_empty, 5'b10111);
            if (k == 4) check("mf_sticky",   FIFO_error, 5'b10000);
        end

        // Reset mid-traffic with push on every FIFO
        cyc(5'b11111, 5'b0, 1'b0, 14'd0, 1'b0);
        check("rst3_empty", FIFO_empty,   5'b11111);
        check("rst3_err",   FIFO_error,   5'b00000);
        check("rst3_ae",    almost_empty, 5'b11111);
        check("rst3_af",    almost_full,  5'b00000);
        cyc(5'b0, 5'b0, 1'b0, 14'd0, 1'b1);
        check("rst3_idle", FIFO_empty, 5'b11111);

        // Threshold reload on D0 at count 2
        cyc(5'b00010, 5'b0, 1'b0, 14'd0, 1'b1);
        cyc(5'b00010, 5'b0, 1'b0, 14'd0, 1'b1);
        check("d0_2_ae", almost_empty, 5'b11101);
        check("d0_2_af", almost_full,  5'b00000);
        cyc(5'b0, 5'b0, 1'b1, c_u2, 1'b1);
        check("reload_ae",  almost_empty, 5'b11111);
        check("reload_af",  almost_full,  5'b00010);
        check("reload_emp", FIFO_empty,   5'b11101);
        // Push applied in an init cycle
        cyc(5'b00010, 5'b0, 1'b1, c_u2, 1'b1);
        check("init_push_ae", almost_empty, 5'b11101);
        check("init_push_af", almost_full,  5'b00010);

        // Maximum thresholds: almost_full at count >= 1
        cyc(5'b0, 5'b0, 1'b1, c_umax, 1'b1);
        check("max_af",  almost_full,  5'b00010);
        check("max_ae",  almost_empty, 5'b11111);
        cyc(5'b10000, 5'b0, 1'b0, 14'd0, 1'b1);
        check("max_af_mf",  almost_full, 5'b10010);
        check("max_emp_mf", FIFO_empty,  5'b01101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
